// File: rtl/imm_gen_pkg.sv
// Opcode constants, immediate format encoding and width helpers shared by the
// immediate generation stage.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;

    // The word-sized opcodes (OP-IMM-32, OP-32) only exist on RV64.
    function automatic bit is_rv64(input int xlen);
        return xlen == 64;
    endfunction

endpackage

// File: rtl/imm_gen_lane.sv
// Combinational decode of one 32-bit instruction word into its XLEN-wide
// immediate, format code and illegal-opcode flag.
module imm_gen_lane
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    localparam bit RV64 = is_rv64(XLEN);

    logic [31:0] imm32;

    // Every format fits in 32 signed bits (zimm is small and positive), so
    // the XLEN result is a plain sign extension of imm32.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                imm32 = {{20{inst[31]}}, inst[31:20]};
                fmt   = FMT_I;
            end
            OPC_OP_IMM_32: begin
                if (RV64) begin
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                    fmt   = FMT_I;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                fmt   = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {inst[31:12], 12'b0};
                fmt   = FMT_U;
            end
            OPC_JAL: begin
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                fmt   = FMT_J;
            end
            OPC_SYSTEM: begin
                if (inst[14]) begin
                    imm32 = {27'b0, inst[19:15]};
                    fmt   = FMT_Z;
                end
            end
            OPC_OP, OPC_FENCE: begin
            end
            OPC_OP_32: begin
                if (!RV64) begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered multi-lane immediate generation stage: per-lane decode feeding an
// output register backed by one skid register so in_ready is a flop.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_vld,
    input  logic [32*LANES-1:0]   in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_vld,
    output logic [XLEN*LANES-1:0] out_imm,
    output logic [3*LANES-1:0]    out_fmt,
    output logic [LANES-1:0]      out_illegal
);

    typedef struct packed {
        logic [LANES-1:0]      lane_vld;
        logic [XLEN*LANES-1:0] imm;
        logic [3*LANES-1:0]    fmt;
        logic [LANES-1:0]      illegal;
    } bundle_t;

    logic [XLEN*LANES-1:0] dec_imm;
    logic [3*LANES-1:0]    dec_fmt;
    logic [LANES-1:0]      dec_illegal;
    bundle_t               dec_bundle;

    bundle_t out_data_d, out_data_q;
    bundle_t skid_data_d, skid_data_q;
    logic    out_valid_d, out_valid_q;
    logic    skid_valid_d, skid_valid_q;
    logic    in_fire, out_fire;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fmt_e lane_fmt;

        imm_gen_lane #(
            .XLEN(XLEN)
        ) u_lane (
            .inst    (in_inst[32*g +: 32]),
            .imm     (dec_imm[XLEN*g +: XLEN]),
            .fmt     (lane_fmt),
            .illegal (dec_illegal[g])
        );

        assign dec_fmt[3*g +: 3] = lane_fmt;
    end

    assign dec_bundle = '{lane_vld: in_lane_vld, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

    assign in_fire  = in_valid & ~skid_valid_q;
    assign out_fire = out_valid_q & out_ready;

    // The skid register only fills while the output register is stalled, so
    // an input transfer and a skid-to-output move never occur together.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else begin
            if (out_fire) begin
                out_valid_d  = skid_valid_q;
                skid_valid_d = 1'b0;
                if (skid_valid_q) begin
                    out_data_d = skid_data_q;
                end
            end
            if (in_fire) begin
                if (!out_valid_q || out_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = dec_bundle;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = dec_bundle;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready     = ~skid_valid_q;
    assign out_valid    = out_valid_q;
    assign out_lane_vld = out_data_q.lane_vld;
    assign out_imm      = out_data_q.imm;
    assign out_fmt      = out_data_q.fmt;
    assign out_illegal  = out_data_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 and an RV64 instance (two lanes each) share
// one stimulus stream and are compared against a queue-based reference model.
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt32;
        logic [2:0]  fmt64;
        logic        ill32;
        logic        ill64;
    } vec_t;

    typedef struct {
        logic [1:0]  vld;
        logic [63:0] inst;
    } bun_t;

    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [1:0]  in_lane_vld;
    logic [63:0] in_inst;

    logic         r32_in_ready, r32_out_valid;
    logic [1:0]   r32_lane_vld, r32_ill;
    logic [63:0]  r32_imm;
    logic [5:0]   r32_fmt;
    logic         r64_in_ready, r64_out_valid;
    logic [1:0]   r64_lane_vld, r64_ill;
    logic [127:0] r64_imm;
    logic [5:0]   r64_fmt;

    int   checks = 0;
    int   failures = 0;
    bun_t q[$];
    bit   zero_out = 1'b1;
    vec_t vec [NV];
    logic [6:0] opcs [13] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                              7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h3B};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .LANES(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32_in_ready),
        .in_lane_vld(in_lane_vld), .in_inst(in_inst), .out_valid(r32_out_valid), .out_ready(out_ready),
        .out_lane_vld(r32_lane_vld), .out_imm(r32_imm), .out_fmt(r32_fmt), .out_illegal(r32_ill)
    );

    imm_gen_pipe #(.XLEN(64), .LANES(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64_in_ready),
        .in_lane_vld(in_lane_vld), .in_inst(in_inst), .out_valid(r64_out_valid), .out_ready(out_ready),
        .out_lane_vld(r64_lane_vld), .out_imm(r64_imm), .out_fmt(r64_fmt), .out_illegal(r64_ill)
    );

    // Interprets an n-bit unsigned field as two's complement.
    function automatic longint sx(input longint f, input int n);
        return (f >= (longint'(1) << (n - 1))) ? f - (longint'(1) << n) : f;
    endfunction

    function automatic void refDecode(input logic [31:0] w, input bit is64,
                                      output logic [63:0] imm, output logic [2:0] fmt,
                                      output logic ill);
        longint v;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: begin fmt = 3'd1; v = sx(longint'(w[31:20]), 12); end
            7'h1B: if (is64) begin fmt = 3'd1; v = sx(longint'(w[31:20]), 12); end else ill = 1'b1;
            7'h23: begin fmt = 3'd2; v = sx(longint'({w[31:25], w[11:7]}), 12); end
            7'h63: begin fmt = 3'd3; v = sx(longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
            7'h37, 7'h17: begin fmt = 3'd4; v = sx(longint'(w[31:12]), 20) * 4096; end
            7'h6F: begin fmt = 3'd5; v = sx(longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
            7'h73: if (w[14]) begin fmt = 3'd6; v = longint'(w[19:15]); end
            7'h33, 7'h0F: ;
            7'h3B: if (!is64) ill = 1'b1;
            default: ill = 1'b1;
        endcase
        imm = is64 ? 64'(v) : {32'b0, v[31:0]};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] vld, input logic [63:0] inst,
                                 input logic ordy, input logic fl);
        in_valid    = v;
        in_lane_vld = vld;
        in_inst     = inst;
        out_ready   = ordy;
        flush       = fl;
    endtask

    task automatic checkOutput();
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        cmp("in_ready32", 64'(r32_in_ready), 64'(q.size() < 2));
        cmp("in_ready64", 64'(r64_in_ready), 64'(q.size() < 2));
        cmp("out_valid32", 64'(r32_out_valid), 64'(q.size() > 0));
        cmp("out_valid64", 64'(r64_out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            cmp("lane_vld32", 64'(r32_lane_vld), 64'(q[0].vld));
            cmp("lane_vld64", 64'(r64_lane_vld), 64'(q[0].vld));
            for (int i = 0; i < 2; i++) begin
                refDecode(q[0].inst[32*i +: 32], 1'b0, e_imm, e_fmt, e_ill);
                cmp($sformatf("imm32_l%0d", i), 64'(r32_imm[32*i +: 32]), e_imm);
                cmp($sformatf("fmt32_l%0d", i), 64'(r32_fmt[3*i +: 3]), 64'(e_fmt));
                cmp($sformatf("ill32_l%0d", i), 64'(r32_ill[i]), 64'(e_ill));
                refDecode(q[0].inst[32*i +: 32], 1'b1, e_imm, e_fmt, e_ill);
                cmp($sformatf("imm64_l%0d", i), r64_imm[64*i +: 64], e_imm);
                cmp($sformatf("fmt64_l%0d", i), 64'(r64_fmt[3*i +: 3]), 64'(e_fmt));
                cmp($sformatf("ill64_l%0d", i), 64'(r64_ill[i]), 64'(e_ill));
            end
        end else if (zero_out) begin
            cmp("zero_imm32", r32_imm, 64'd0);
            cmp("zero_imm64", r64_imm[63:0] | r64_imm[127:64], 64'd0);
            cmp("zero_misc", 64'({r32_fmt, r64_fmt, r32_ill, r64_ill, r32_lane_vld, r64_lane_vld}), 64'd0);
        end
    endtask

    // One clock: check state from the previous edge, then advance the model.
    task automatic tick();
        bit acc, drn;
        checkOutput();
        acc = rst_n && !flush && in_valid && (q.size() < 2);
        drn = out_ready && (q.size() > 0);
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
            zero_out = 1'b1;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back('{vld: in_lane_vld, inst: in_inst});
                zero_out = 1'b0;
            end
        end
        #1;
    endtask

    task automatic tableCheck(input int lane, input int idx);
        cmp($sformatf("tbl%0d_imm32", idx), 64'(r32_imm[32*lane +: 32]), {32'b0, vec[idx].imm[31:0]});
        cmp($sformatf("tbl%0d_imm64", idx), r64_imm[64*lane +: 64], vec[idx].imm);
        cmp($sformatf("tbl%0d_fmt32", idx), 64'(r32_fmt[3*lane +: 3]), 64'(vec[idx].fmt32));
        cmp($sformatf("tbl%0d_fmt64", idx), 64'(r64_fmt[3*lane +: 3]), 64'(vec[idx].fmt64));
        cmp($sformatf("tbl%0d_ill32", idx), 64'(r32_ill[lane]), 64'(vec[idx].ill32));
        cmp($sformatf("tbl%0d_ill64", idx), 64'(r64_ill[lane]), 64'(vec[idx].ill64));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] rinst;
        vec[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0};
        vec[1]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 3'd3, 1'b0, 1'b0};
        vec[2]  = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0};
        vec[3]  = '{32'h300FD073, 64'h000000000000001F, 3'd6, 3'd6, 1'b0, 1'b0};
        vec[4]  = '{32'h0000001B, 64'h0000000000000000, 3'd0, 3'd1, 1'b1, 1'b0};
        vec[5]  = '{32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1};
        vec[6]  = '{32'hFE20AC23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 3'd2, 1'b0, 1'b0};
        vec[7]  = '{32'h001000EF, 64'h0000000000000800, 3'd5, 3'd5, 1'b0, 1'b0};
        vec[8]  = '{32'h80000067, 64'hFFFFFFFFFFFFF800, 3'd1, 3'd1, 1'b0, 1'b0};
        vec[9]  = '{32'h00000033, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0};
        vec[10] = '{32'h0000000F, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0};
        vec[11] = '{32'h00000073, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0};
        vec[12] = '{32'h0000003B, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b0};
        vec[13] = '{32'h12345017, 64'h0000000012345000, 3'd4, 3'd4, 1'b0, 1'b0};
        vec[14] = '{32'hFFF00090, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1};

        rst_n = 1'b0;
        applyStimulus(1'b1, 2'b11, 64'h00100093_00100093, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'b00, 64'd0, 1'b1, 1'b0);
        tick();

        // Streaming table: each bundle must appear exactly one edge later.
        for (int i = 0; i < NV; i++) begin
            applyStimulus(1'b1, 2'b11, {vec[(i + 1) % NV].inst, vec[i].inst}, 1'b1, 1'b0);
            tick();
            cmp($sformatf("tbl%0d_valid", i), 64'(r32_out_valid & r64_out_valid), 64'd1);
            tableCheck(0, i);
            tableCheck(1, (i + 1) % NV);
        end
        applyStimulus(1'b0, 2'b00, 64'd0, 1'b1, 1'b0);
        tick();

        // Backpressure: A and B held, C stalled, then drained in order.
        applyStimulus(1'b1, 2'b01, 64'h00000013_00100093, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b01, 64'h00000013_00200093, 1'b0, 1'b0);
        tick();
        cmp("bp_in_ready_low", 64'(r32_in_ready | r64_in_ready), 64'd0);
        applyStimulus(1'b1, 2'b01, 64'h00000013_00300093, 1'b0, 1'b0);
        tick();
        cmp("bp_hold_A", r64_imm[63:0], 64'd1);
        cmp("bp_still_blocked", 64'(r32_in_ready), 64'd0);
        applyStimulus(1'b1, 2'b01, 64'h00000013_00300093, 1'b1, 1'b0);
        tick();
        cmp("bp_out_B", r64_imm[63:0], 64'd2);
        tick();
        cmp("bp_out_C", r64_imm[63:0], 64'd3);
        cmp("bp_C_valid", 64'(r64_out_valid), 64'd1);
        applyStimulus(1'b0, 2'b00, 64'd0, 1'b1, 1'b0);
        tick();

        // Flush with both entries full and a bundle offered on the flush cycle.
        applyStimulus(1'b1, 2'b11, 64'h00000013_00400093, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b11, 64'h00000013_00500093, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b11, 64'h00000013_7FF00093, 1'b0, 1'b1);
        tick();
        cmp("fl_out_valid", 64'(r32_out_valid | r64_out_valid), 64'd0);
        cmp("fl_in_ready", 64'(r32_in_ready & r64_in_ready), 64'd1);
        applyStimulus(1'b0, 2'b00, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("fl_never_appears", 64'(r32_out_valid | r64_out_valid), 64'd0);
        end
        applyStimulus(1'b1, 2'b11, 64'h00000013_7FF00093, 1'b1, 1'b1);
        tick();
        cmp("fl_empty_discard", 64'(r64_out_valid), 64'd0);

        // Reset pulse while a result is pending.
        applyStimulus(1'b1, 2'b11, 64'h00000013_00500093, 1'b0, 1'b0);
        tick();
        cmp("rst_pre_valid", 64'(r64_out_valid), 64'd1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 2'b00, 64'd0, 1'b0, 1'b0);
        tick();
        cmp("rst_out_valid", 64'(r32_out_valid | r64_out_valid), 64'd0);
        cmp("rst_imm", r64_imm[63:0] | r32_imm, 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'b11, 64'h00000013_00600093, 1'b1, 1'b0);
        tick();
        cmp("rst_new_valid", 64'(r64_out_valid), 64'd1);
        cmp("rst_new_imm", r64_imm[63:0], 64'd6);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            rinst = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) rinst[6:0] = opcs[$urandom_range(0, 12)];
            if ($urandom_range(0, 7) != 0) rinst[38:32] = opcs[$urandom_range(0, 12)];
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rinst,
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
            tick();
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'b00, 64'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
